// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 frame scheduler and its frame buffer.
package ws2812_pkg;

    typedef logic [23:0] pixel_t;  // GRB, G in [23:16]

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_LOAD  = 5'b00010,
        S_START = 5'b00100,
        S_BUSY  = 5'b01000,
        S_LATCH = 5'b10000
    } state_t;

    localparam real F_CLK_DEF   = 48.0e6;
    localparam real T_RESET_DEF = 80.0e-6;

    // ceil(f_clk * t_reset), tolerant of binary rounding just above an integer
    function automatic int calc_n_reset(input real f_clk, input real t_reset);
        real x;
        int  n;
        x = f_clk * t_reset;
        n = $rtoi(x);
        if (x - $itor(n) > 1.0e-6) n = n + 1;
        return n;
    endfunction

    function automatic pixel_t scale_px(input pixel_t p, input logic [7:0] b);
        logic [15:0] t;
        pixel_t      r;
        r = '0;
        for (int ch = 0; ch < 3; ch++) begin
            t = {8'd0, p[ch*8 +: 8]} * ({8'd0, b} + 16'd1);
            r[ch*8 +: 8] = t[15:8];
        end
        return r;
    endfunction

endpackage

// File: rtl/ws2812_fb.sv
// Pixel frame buffer: DEPTH x 24 register file, one write port, one combinational read port.
module ws2812_fb
    import ws2812_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          i_clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [23:0]   i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [23:0]   o_rd_data
);

    // Contents are deliberately not reset; the host fills them before use.
    pixel_t r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// Frame scheduler: walks every pixel through ws2812_tx, then holds the latch gap.
// Define WS2812_BRIGHTNESS_EN to scale each pixel by the brightness captured at frame start.
module ws2812_frame_ctrl
    import ws2812_pkg::*;
#(
    parameter real F_CLK   = F_CLK_DEF,
    parameter int  N       = 7,
    parameter real T_RESET = T_RESET_DEF,
    localparam int N_RESET = calc_n_reset(F_CLK, T_RESET),
    localparam int CNT_W   = $clog2(N_RESET),
    localparam int IDX_W   = (N > 0) ? $clog2(N + 1) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_addr,
    input  logic [23:0]      i_wr_data,
    input  logic [7:0]       i_brightness,
    input  logic             i_frame_req,
    output logic             o_frame_ack,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_tx_start,
    output logic [23:0]      o_tx_data,
    input  logic             i_tx_bsy
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_RESET - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tx_start, r_busy, r_ack, r_done;
    logic [23:0]      r_tx_data;
    logic [IDX_W-1:0] w_rd_addr;
    logic [23:0]      w_rd_px, w_load_px;

    // Read port always points at the pixel the next LOAD entry will capture.
    always_comb begin
        w_rd_addr = '0;
        if (r_state != S_IDLE && r_idx != IDX_LAST) w_rd_addr = r_idx + IDX_W'(1);
    end

    ws2812_fb #(.DEPTH(N + 1), .AW(IDX_W)) u_fb (
        .i_clk     (i_clk),
        .i_wr_en   (i_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_px)
    );

`ifdef WS2812_BRIGHTNESS_EN
    logic [7:0] r_bri;
    logic [7:0] w_bri_sel;
    // Pixel 0 loads on the same edge that captures brightness, so bypass the register there.
    assign w_bri_sel = (r_state == S_IDLE) ? i_brightness : r_bri;
    assign w_load_px = scale_px(w_rd_px, w_bri_sel);
`else
    logic w_unused_bri;
    assign w_unused_bri = ^i_brightness;
    assign w_load_px    = w_rd_px;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_busy     <= 1'b0;
            r_ack      <= 1'b0;
            r_done     <= 1'b0;
`ifdef WS2812_BRIGHTNESS_EN
            r_bri      <= '0;
`endif
        end else begin
            r_ack  <= 1'b0;
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_frame_req) begin
                        r_idx      <= '0;
`ifdef WS2812_BRIGHTNESS_EN
                        r_bri      <= i_brightness;
`endif
                        r_tx_data  <= w_load_px;
                        r_tx_start <= 1'b1;
                        r_busy     <= 1'b1;
                        r_ack      <= 1'b1;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: r_state <= S_START;
                S_START: begin
                    r_tx_start <= 1'b0;
                    r_state    <= S_BUSY;
                end
                S_BUSY: begin
                    if (!i_tx_bsy) begin
                        if (r_idx == IDX_LAST) begin
                            r_cnt   <= '0;
                            r_state <= S_LATCH;
                        end else begin
                            r_idx      <= r_idx + IDX_W'(1);
                            r_tx_data  <= w_load_px;
                            r_tx_start <= 1'b1;
                            r_state    <= S_LOAD;
                        end
                    end
                end
                S_LATCH: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_tx_start <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign o_frame_ack = r_ack;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_tx_start  = r_tx_start;
    assign o_tx_data   = r_tx_data;

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Directed + randomized bench for ws2812_frame_ctrl with a behavioural tx responder and frame model.
module tb_ws2812_frame_ctrl;

    localparam int N           = 7;
    localparam int NPIX        = N + 1;
    localparam int N_RESET_EXP = 3840;

    logic        clk = 1'b0;
    logic        rst, wr_en, frame_req;
    logic [2:0]  wr_addr;
    logic [23:0] wr_data;
    logic [7:0]  brightness;
    logic        frame_ack, busy, done, tx_start;
    logic [23:0] tx_data;
    logic        tx_bsy = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ws2812_frame_ctrl #(.N(N)) dut (
        .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_brightness(brightness), .i_frame_req(frame_req), .o_frame_ack(frame_ack),
        .o_busy(busy), .o_done(done), .o_tx_start(tx_start), .o_tx_data(tx_data), .i_tx_bsy(tx_bsy)
    );

    // tx responder: tx_bsy stays high for hold_tab[k] cycles after the k-th start strobe ends
    int hold_tab [64];
    int m_nstart = 0, m_rem = 0, m_h = 0;
    bit m_prev = 1'b0;
    always @(posedge clk) begin
        if (rst !== 1'b1) begin
            m_rem  = 0;
            m_prev = 1'b0;
        end else begin
            if (tx_start === 1'b1) begin
                if (!m_prev) begin
                    m_h = hold_tab[m_nstart % 64];
                    m_nstart++;
                end
                m_rem = m_h;
            end else if (m_rem > 0) begin
                m_rem--;
            end
            m_prev = (tx_start === 1'b1);
        end
        tx_bsy <= (m_rem > 0);
    end

    // Event recorder
    logic [23:0] mon_data [256];
    int mon_scyc [256];
    int mon_len  [256];
    int mon_ack_cyc [64];
    int mon_done_cyc [64];
    int mon_nstart = 0, mon_run = 0, mon_viol = 0, mon_nack = 0, mon_ndone = 0, mon_nbusy = 0;
    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            if (mon_run == 0) begin
                mon_data[mon_nstart % 256] = tx_data;
                mon_scyc[mon_nstart % 256] = cyc;
                if (tx_bsy === 1'b1) mon_viol++;
                mon_nstart++;
            end
            mon_run++;
        end else if (mon_run > 0) begin
            mon_len[(mon_nstart - 1) % 256] = mon_run;
            mon_run = 0;
        end
        if (frame_ack === 1'b1) begin
            mon_ack_cyc[mon_nack % 64] = cyc;
            mon_nack++;
        end
        if (done === 1'b1) begin
            mon_done_cyc[mon_ndone % 64] = cyc;
            mon_ndone++;
        end
        if (busy === 1'b1) mon_nbusy++;
    end

    logic [23:0] fb_m   [NPIX];
    logic [23:0] exp_px [NPIX];
    logic [7:0]  bri_acc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] model_px(input logic [23:0] p, input int b);
`ifdef WS2812_BRIGHTNESS_EN
        int r = 0;
        for (int ch = 0; ch < 3; ch++) begin
            int c = (int'(p) >> (8 * ch)) & 255;
            r = r | (((c * (b + 1)) / 256) << (8 * ch));
        end
        return 24'(r);
`else
        return p;
`endif
    endfunction

    task automatic wr(input int a, input logic [23:0] d);
        wr_en   = 1'b1;
        wr_addr = 3'(a);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        fb_m[a] = d;
    endtask

    task automatic prep_holds(input int base, input int cnt, input int lo, input int hi);
        for (int i = 0; i < cnt; i++) hold_tab[(base + i) % 64] = int'($urandom_range(hi, lo));
    endtask

    task automatic snap_exp();
        bri_acc = brightness;
        for (int i = 0; i < NPIX; i++) exp_px[i] = model_px(fb_m[i], int'(brightness));
    endtask

    task automatic wait_ack(input string tag);
        int n = 0;
        while (frame_ack !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_ack_seen"}, 32'(frame_ack), 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tx_start"}, 32'(tx_start), 0);
        check({tag, "_tx_data"}, 32'(tx_data), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_frame_ack"}, 32'(frame_ack), 0);
        check({tag, "_done"}, 32'(done), 0);
    endtask

    task automatic start_frame(input string tag, input bit keep, output int ack_c,
                               output int bs, output int ba, output int bd, output int bb);
        bs = mon_nstart; ba = mon_nack; bd = mon_ndone; bb = mon_nbusy;
        snap_exp();
        frame_req = 1'b1;
        ack_c = cyc + 1;
        wait_ack(tag);
        if (!keep) begin
            frame_req  = 1'b0;
            brightness = 8'($urandom);
        end
    endtask

    task automatic check_frame(input string tag, input int ack_c, input int bs, input int ba,
                               input int bd, input int bb, output int exp_done);
        int s = ack_c;
        int n = 0;
        for (int i = 0; i < NPIX; i++) s += 3 + hold_tab[(bs + i) % 64];
        exp_done = s + N_RESET_EXP;
        while (mon_ndone <= bd && n < 10000) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 32'(mon_ndone > bd), 1);
        check({tag, "_ack_count"}, 32'(mon_nack - ba), 1);
        check({tag, "_ack_cyc"}, 32'(mon_ack_cyc[ba % 64]), 32'(ack_c));
        check({tag, "_n_pixels"}, 32'(mon_nstart - bs), NPIX);
        s = ack_c;
        for (int i = 0; i < NPIX; i++) begin
            check($sformatf("%s_px%0d_data", tag, i), 32'(mon_data[(bs + i) % 256]), 32'(exp_px[i]));
            check($sformatf("%s_px%0d_cyc", tag, i), 32'(mon_scyc[(bs + i) % 256]), 32'(s));
            check($sformatf("%s_px%0d_strobe_len", tag, i), 32'(mon_len[(bs + i) % 256]), 2);
            s += 3 + hold_tab[(bs + i) % 64];
        end
        check({tag, "_start_while_bsy"}, 32'(mon_viol), 0);
        check({tag, "_done_cyc"}, 32'(mon_done_cyc[bd % 64]), 32'(exp_done));
        check({tag, "_busy_cycles"}, 32'(mon_nbusy - bb), 32'(exp_done - ack_c));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ack_c, bs, ba, bd, bb, ed, n;
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; brightness = '0; frame_req = 1'b0;
        for (int i = 0; i < 64; i++) hold_tab[i] = 0;
        repeat (3) tick();
        check_outputs_zero("reset");
        rst = 1'b1;
        tick();

        // Basic frame
        for (int i = 0; i < NPIX; i++) wr(i, 24'(i + 1));
        brightness = 8'hFF;
        prep_holds(mon_nstart, NPIX, 2, 2);
        start_frame("basic", 1'b0, ack_c, bs, ba, bd, bb);
        check_frame("basic", ack_c, bs, ba, bd, bb, ed);

        // Busy hold of 10 cycles: 13-cycle pixel period
        prep_holds(mon_nstart, NPIX, 10, 10);
        start_frame("hold10", 1'b0, ack_c, bs, ba, bd, bb);
        check_frame("hold10", ack_c, bs, ba, bd, bb, ed);
        check("hold10_period", 32'(mon_scyc[(bs + 1) % 256] - mon_scyc[bs % 256]), 13);

        // Request held through a frame: back-to-back frames
        prep_holds(mon_nstart, 2 * NPIX, 0, 4);
        start_frame("b2b1", 1'b1, ack_c, bs, ba, bd, bb);
        check_frame("b2b1", ack_c, bs, ba, bd, bb, ed);
        bs = mon_nstart; ba = mon_nack; bd = mon_ndone; bb = mon_nbusy;
        snap_exp();
        ack_c = ed + 1;
        wait_ack("b2b2");
        frame_req = 1'b0;
        check_frame("b2b2", ack_c, bs, ba, bd, bb, ed);

        // Writes while pixel 3 is in flight
        prep_holds(mon_nstart, NPIX, 6, 6);
        start_frame("midwr", 1'b0, ack_c, bs, ba, bd, bb);
        n = 0;
        while (!((mon_nstart - bs) >= 4 && tx_start === 1'b0) && n < 2000) begin
            tick();
            n++;
        end
        check("midwr_reach_px3", 32'(mon_nstart - bs), 4);
        wr(5, 24'hABCDEF);
        wr(0, 24'h123456);
        exp_px[5] = model_px(24'hABCDEF, int'(bri_acc));
        check_frame("midwr", ack_c, bs, ba, bd, bb, ed);
        prep_holds(mon_nstart, NPIX, 0, 3);
        start_frame("midwr_next", 1'b0, ack_c, bs, ba, bd, bb);
        check_frame("midwr_next", ack_c, bs, ba, bd, bb, ed);

        // Brightness scaling
        wr(2, 24'hFF8040);
        brightness = 8'h7F;
        prep_holds(mon_nstart, NPIX, 1, 1);
        start_frame("bri", 1'b0, ack_c, bs, ba, bd, bb);
        check_frame("bri", ack_c, bs, ba, bd, bb, ed);
`ifdef WS2812_BRIGHTNESS_EN
        check("bri_px2_const", 32'(mon_data[(bs + 2) % 256]), 32'h7F4020);
`else
        check("bri_px2_const", 32'(mon_data[(bs + 2) % 256]), 32'hFF8040);
`endif

        // Reset during BUSY of pixel 4, then restart from pixel 0
        prep_holds(mon_nstart, NPIX, 5, 5);
        start_frame("rst_abort", 1'b0, ack_c, bs, ba, bd, bb);
        n = 0;
        while (!((mon_nstart - bs) >= 5 && tx_start === 1'b0) && n < 2000) begin
            tick();
            n++;
        end
        check("rst_reach_px4", 32'(mon_nstart - bs), 5);
        rst = 1'b0;
        tick();
        check_outputs_zero("rst_mid");
        rst = 1'b1;
        tick();
        prep_holds(mon_nstart, NPIX, 0, 5);
        start_frame("rst_restart", 1'b0, ack_c, bs, ba, bd, bb);
        check_frame("rst_restart", ack_c, bs, ba, bd, bb, ed);

        // Randomized frames, including brightness extremes
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NPIX; i++) wr(i, 24'($urandom));
            case (k)
                0:       brightness = 8'h00;
                1:       brightness = 8'hFF;
                default: brightness = 8'($urandom);
            endcase
            prep_holds(mon_nstart, NPIX, 0, 6);
            start_frame($sformatf("rnd%0d", k), 1'b0, ack_c, bs, ba, bd, bb);
            check_frame($sformatf("rnd%0d", k), ack_c, bs, ba, bd, bb, ed);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
